// File: rtl/delay_latency_sequencer.sv
// delay_latency_sequencer
//
// Drives the latency input of a variable delay line (luma/chroma alignment)
// and sequences latency changes. A new latency is accepted over a
// valid/ready handshake, applied on the next video line boundary, and then
// the controller waits until the delay line's read index has re-synchronised.
// That wait is 2^SIZE + L + 2 cycles for the new latency L.
//
// Optional feature macro: DELAY_SEQ_MUTE_EN
//   defined   : mute is high while the delay line re-synchronises
//   undefined : mute is tied to 0 and downstream sees the transient;
//               busy/done timing is identical in both builds
//
// Parameters
//   SIZE           index width of the driven delay line (latency 0..2^SIZE-1)
//   RESET_LATENCY  latency driven after reset
//
// Ports
//   clk          system clock, all logic on posedge
//   reset        synchronous, active-high reset
//   req_valid    new latency request present
//   req_latency  requested latency, sampled on accept
//   req_ready    controller can accept a request (IDLE only)
//   line_start   single-cycle strobe at the start of each video line
//   latency      registered latency to the delay line
//   mute         delay-line output not yet valid
//   busy         high in any state other than IDLE
//   done         one-cycle pulse when a change has fully settled
module delay_latency_sequencer #(
  parameter int              SIZE          = 5,
  parameter logic [SIZE-1:0] RESET_LATENCY = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic [SIZE-1:0] req_latency,
  output logic            req_ready,
  input  logic            line_start,
  output logic [SIZE-1:0] latency,
  output logic            mute,
  output logic            busy,
  output logic            done
);

  // Counter is two bits wider than the index so 2^SIZE + (2^SIZE-1) + 2
  // fits without wrapping.
  localparam int            CW    = SIZE + 2;
  localparam logic [CW-1:0] DEPTH = CW'(2 ** SIZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SETTLE  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   settle_cnt, settle_cnt_n;
  logic [SIZE-1:0] latency_n;
  logic [SIZE-1:0] pend;
  logic            busy_n, req_ready_n, done_n;

  // Worst case: read index above the new L runs to the top of the memory,
  // wraps, refills L+1 entries, plus the delay line's output register.
  function automatic logic [CW-1:0] settle_len(input logic [SIZE-1:0] l);
    settle_len = DEPTH + {2'b00, l} + CW'(2);
  endfunction

  always_comb begin
    state_n      = state;
    settle_cnt_n = settle_cnt;
    latency_n    = latency;
    busy_n       = busy;
    req_ready_n  = req_ready;
    done_n       = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          // A request for the latency already in force settles immediately.
          if (req_latency == latency) begin
            done_n = 1'b1;
          end else begin
            state_n     = PENDING;
            busy_n      = 1'b1;
            req_ready_n = 1'b0;
          end
        end
      end
      PENDING: begin
        if (line_start) begin
          latency_n    = pend;
          settle_cnt_n = settle_len(pend);
          state_n      = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == CW'(1)) begin
          state_n     = IDLE;
          busy_n      = 1'b0;
          req_ready_n = 1'b1;
          done_n      = 1'b1;
        end
        settle_cnt_n = settle_cnt - CW'(1);
      end
      default: begin
        state_n     = IDLE;
        busy_n      = 1'b0;
        req_ready_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SETTLE;
      latency    <= RESET_LATENCY;
      settle_cnt <= settle_len(RESET_LATENCY);
      busy       <= 1'b1;
      req_ready  <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      latency    <= latency_n;
      settle_cnt <= settle_cnt_n;
      busy       <= busy_n;
      req_ready  <= req_ready_n;
      done       <= done_n;
    end
  end

  // Request holding register: data only, loaded on accept.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid && req_ready) begin
      pend <= req_latency;
    end
  end

`ifdef DELAY_SEQ_MUTE_EN
  // Registered so mute rises on the same edge as the latency update.
  always_ff @(posedge clk) begin
    if (reset) begin
      mute <= 1'b1;
    end else begin
      mute <= (state_n == SETTLE);
    end
  end
`else
  assign mute = 1'b0;
`endif

endmodule

// File: tb/tb_delay_latency_sequencer.sv
// Directed bench for delay_latency_sequencer (SIZE=5, RESET_LATENCY=0).
// Includes a simple delay-line model driven by the controller's latency.
module tb_delay_latency_sequencer;

  localparam int SIZE = 5;

`ifdef DELAY_SEQ_MUTE_EN
  localparam int MUTE_ON = 1;
`else
  localparam int MUTE_ON = 0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            req_valid = 1'b0;
  logic [SIZE-1:0] req_latency = '0;
  logic            req_ready;
  logic            line_start = 1'b0;
  logic [SIZE-1:0] latency;
  logic            mute;
  logic            busy;
  logic            done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  delay_latency_sequencer #(
    .SIZE          (SIZE),
    .RESET_LATENCY (5'd0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_latency (req_latency),
    .req_ready   (req_ready),
    .line_start  (line_start),
    .latency     (latency),
    .mute        (mute),
    .busy        (busy),
    .done        (done)
  );

  // Delay-line model: 32-entry memory, read L+1 entries behind the write
  // pointer into an output register, giving L+1 cycles of delay.
  logic [7:0] mem [32];
  logic [4:0] wp   = '0;
  logic [7:0] din  = '0;
  logic [7:0] dout = '0;

  always @(posedge clk) begin
    mem[wp] <= din;
    wp      <= wp + 5'd1;
    dout    <= mem[wp - latency - 5'd1];
    din     <= din + 8'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with busy high (bounded), plus mute, req_ready and done
  // samples seen during that window.
  task automatic run_busy(output int n, output int m, output int r, output int d);
    n = 0; m = 0; r = 0; d = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (mute === 1'b1) m++;
      if (req_ready === 1'b1) r++;
      if (done === 1'b1) d++;
      tick();
    end
  endtask

  int n, m, r, d, bad;

  initial begin
    // 1: reset
    tick();
    reset = 1'b0;
    check("rst_latency", 32'(latency), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mute", 32'(mute), 32'(MUTE_ON));
    run_busy(n, m, r, d);
    check("rst_busy_len", 32'(n), 32'd34);
    check("rst_mute_len", 32'(m), 32'(MUTE_ON * 34));
    check("rst_done_in_busy", 32'(d), 32'd0);
    check("rst_done", 32'(done), 32'd1);
    check("rst_ready_after", 32'(req_ready), 32'd1);
    check("rst_mute_after", 32'(mute), 32'd0);
    tick();
    check("rst_done_once", 32'(done), 32'd0);

    // 2: request 10, line_start 50 cycles later
    req_valid = 1'b1; req_latency = 5'd10;
    tick();
    req_valid = 1'b0;
    check("t2_pending_busy", 32'(busy), 32'd1);
    check("t2_pending_ready", 32'(req_ready), 32'd0);
    bad = 0;
    for (int i = 0; i < 49; i++) begin
      if (latency !== 5'd0 || mute !== 1'b0) bad++;
      tick();
    end
    check("t2_latency_held", 32'(bad), 32'd0);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    check("t2_latency", 32'(latency), 32'd10);
    check("t2_mute_edge", 32'(mute), 32'(MUTE_ON));
    run_busy(n, m, r, d);
    check("t2_settle_len", 32'(n), 32'd44);
    check("t2_mute_len", 32'(m), 32'(MUTE_ON * 44));
    check("t2_done", 32'(done), 32'd1);
    tick();
    check("t2_done_once", 32'(done), 32'd0);

    // 3: request equal to current latency
    req_valid = 1'b1; req_latency = 5'd10;
    tick();
    req_valid = 1'b0;
    check("t3_done", 32'(done), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_mute", 32'(mute), 32'd0);
    check("t3_latency", 32'(latency), 32'd10);
    tick();
    check("t3_done_once", 32'(done), 32'd0);

    // 4: line_start coincident with accept of 31 is ignored
    req_valid = 1'b1; req_latency = 5'd31; line_start = 1'b1;
    tick();
    req_valid = 1'b0; line_start = 1'b0;
    check("t4_busy", 32'(busy), 32'd1);
    repeat (5) tick();
    check("t4_latency_held", 32'(latency), 32'd10);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    check("t4_latency", 32'(latency), 32'd31);
    run_busy(n, m, r, d);
    check("t4_settle_len", 32'(n), 32'd65);
    check("t4_mute_len", 32'(m), 32'(MUTE_ON * 65));
    check("t4_done", 32'(done), 32'd1);
    tick();

    // 5: reset mid-SETTLE of latency 20
    req_valid = 1'b1; req_latency = 5'd20;
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    check("t5_latency", 32'(latency), 32'd20);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_latency", 32'(latency), 32'd0);
    check("t5_rst_ready", 32'(req_ready), 32'd0);
    check("t5_rst_mute", 32'(mute), 32'(MUTE_ON));
    run_busy(n, m, r, d);
    check("t5_settle_len", 32'(n), 32'd34);
    check("t5_done", 32'(done), 32'd1);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    check("t5_dropped_latency", 32'(latency), 32'd0);
    check("t5_dropped_busy", 32'(busy), 32'd0);

    // 6: request 7 held while busy with an earlier change to 3
    req_valid = 1'b1; req_latency = 5'd3;
    tick();
    req_latency = 5'd7;
    check("t6_ready_pending", 32'(req_ready), 32'd0);
    repeat (2) tick();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    check("t6_latency3", 32'(latency), 32'd3);
    run_busy(n, m, r, d);
    check("t6_settle3_len", 32'(n), 32'd37);
    check("t6_ready_held_off", 32'(r), 32'd0);
    check("t6_idle_ready", 32'(req_ready), 32'd1);
    check("t6_done3", 32'(done), 32'd1);
    tick();
    req_valid = 1'b0;
    check("t6_accept7_busy", 32'(busy), 32'd1);
    check("t6_accept7_done", 32'(done), 32'd0);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    check("t6_latency7", 32'(latency), 32'd7);
    run_busy(n, m, r, d);
    check("t6_settle7_len", 32'(n), 32'd41);
    check("t6_done7", 32'(done), 32'd1);
    // din advances every edge, so the value sampled 8 edges ago is din-9.
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (dout !== 8'(din - 8'd9)) bad++;
      tick();
    end
    check("t6_delay8", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
